timer_apb_regs: RTL and testbench

APB3 slave register front-end that programs the general-purpose timer. It sits directly upstream of the timer core. It drives the core's configuration and start inputs: mode, prescaler, reload_val, compare_val and start. It consumes timeout, pwm_out and current_count for status readback, a sticky timeout flag and a registered interrupt.

---
 rtl/timer_apb_regs.sv | 126 ++++++++++++
 tb/tb_timer_apb_regs.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB3 register front-end for the timer core (config, start pulse, sticky timeout flag, irq).
//   Ports: clk/rst_n (async active-low); APB3 slave psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr;
//   to core: mode, prescaler, reload_val, compare_val, start; from core: timeout, pwm_out, current_count; irq out.
//   Optional macro TIMER_APB_SHADOW_EN: RELOAD/COMPARE writes go to shadows, loaded on timeout rise or start.
module timer_apb_regs #(
    parameter int          WAIT_STATES   = 0,
    parameter logic [15:0] PRESCALER_RST = 16'd0,
    parameter logic [31:0] RELOAD_RST    = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [1:0]  mode,
    output logic [15:0] prescaler,
    output logic [31:0] reload_val,
    output logic [31:0] compare_val,
    output logic        start,
    input  logic        timeout,
    input  logic        pwm_out,
    input  logic [31:0] current_count,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    state_t      state, state_nx;
    logic [2:0]  wcnt;
    logic        flag, irq_en, to_prev;
    logic        done, err, wr, rise, flag_nx, en_nx;
    logic        we_ctrl, we_presc, we_reload, we_compare, we_status, we_en;
    logic [5:0]  idx;
    logic [31:0] rd, reload_rd, compare_rd;
    logic        unused;
    assign unused = &{1'b0, paddr[1:0]};
    // the transfer completes only while psel is still held; dropping psel in ACCESS aborts
    assign done = state == ACCESS && psel && wcnt == WS;
    assign idx  = paddr[7:2];
    assign err  = idx > 6'd6 || (pwrite && idx == 6'd6);
    assign wr   = done && pwrite && !err;
    assign we_ctrl    = wr && idx == 6'd0;
    assign we_presc   = wr && idx == 6'd1;
    assign we_reload  = wr && idx == 6'd2;
    assign we_compare = wr && idx == 6'd3;
    assign we_status  = wr && idx == 6'd4;
    assign we_en      = wr && idx == 6'd5;
    assign rise = timeout && !to_prev;
    // a timeout rise landing on a W1C commit keeps the flag set
    assign flag_nx = rise || (flag && !(we_status && pwdata[0]));
    assign en_nx   = we_en ? pwdata[0] : irq_en;
    always_comb begin
        state_nx = state == IDLE ? ((psel && !penable) ? SETUP : IDLE) :
                   state == SETUP ? ACCESS :
                   (!psel || wcnt == WS) ? IDLE : ACCESS;
        rd = idx == 6'd0 ? {30'd0, mode} :
             idx == 6'd1 ? {16'd0, prescaler} :
             idx == 6'd2 ? reload_rd :
             idx == 6'd3 ? compare_rd :
             idx == 6'd4 ? {30'd0, pwm_out, flag} :
             idx == 6'd5 ? {31'd0, irq_en} :
             idx == 6'd6 ? current_count : 32'd0;
        pready  = done;
        pslverr = done && err;
        prdata  = (done && !pwrite && !err) ? rd : 32'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= 3'd0;
            mode      <= 2'd0;
            prescaler <= PRESCALER_RST;
            start     <= 1'b0;
            to_prev   <= 1'b0;
            flag      <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state   <= state_nx;
            wcnt    <= (state == ACCESS && psel && wcnt != WS) ? wcnt + 3'd1 : 3'd0;
            if (we_ctrl) mode <= pwdata[1:0];
            if (we_presc) prescaler <= pwdata[15:0];
            start   <= we_ctrl && pwdata[2];
            to_prev <= timeout;
            flag    <= flag_nx;
            irq_en  <= en_nx;
            irq     <= flag_nx && en_nx;
        end
    end
`ifdef TIMER_APB_SHADOW_EN
    logic [31:0] reload_sh, compare_sh;
    assign reload_rd  = reload_sh;
    assign compare_rd = compare_sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_sh   <= RELOAD_RST;
            compare_sh  <= 32'd0;
            reload_val  <= RELOAD_RST;
            compare_val <= 32'd0;
        end else begin
            if (we_reload) reload_sh <= pwdata;
            if (we_compare) compare_sh <= pwdata;
            if (rise || start) begin
                reload_val  <= reload_sh;
                compare_val <= compare_sh;
            end
        end
    end
`else
    assign reload_rd  = reload_val;
    assign compare_rd = compare_val;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_val  <= RELOAD_RST;
            compare_val <= 32'd0;
        end else begin
            if (we_reload) reload_val <= pwdata;
            if (we_compare) compare_val <= pwdata;
        end
    end
`endif
endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs: randomized APB traffic against a register-level model of timer_apb_regs.
module tb_timer_apb_regs;
    localparam int          WS = 2;
    localparam logic [15:0] PR = 16'h1234;
    localparam logic [31:0] RR = 32'hCAFE_0000;
`ifdef TIMER_APB_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = 8'd0;
    logic [31:0] pwdata = 32'd0, prdata;
    logic        pready, pslverr, start, irq;
    logic [1:0]  mode;
    logic [15:0] prescaler;
    logic [31:0] reload_val, compare_val;
    logic        timeout = 1'b0, pwm_out = 1'b0;
    logic [31:0] current_count = 32'd0;
    int n_checks = 0, n_fails = 0;

    timer_apb_regs #(.WAIT_STATES(WS), .PRESCALER_RST(PR), .RELOAD_RST(RR)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mode(mode), .prescaler(prescaler), .reload_val(reload_val), .compare_val(compare_val),
        .start(start), .timeout(timeout), .pwm_out(pwm_out), .current_count(current_count), .irq(irq));

    always #5 clk = ~clk;

    // register-level model: programmed values, live core values and sticky state
    logic [1:0]  m_mode;
    logic [15:0] m_presc;
    logic [31:0] m_reload, m_compare, m_reload_live, m_compare_live;
    logic        m_flag, m_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_presc = PR; m_reload = RR; m_compare = 0;
        m_reload_live = RR; m_compare_live = 0; m_flag = 0; m_en = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a >> 2)
            0: return {30'd0, m_mode};
            1: return {16'd0, m_presc};
            2: return m_reload;
            3: return m_compare;
            4: return {30'd0, pwm_out, m_flag};
            5: return {31'd0, m_en};
            6: return current_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_mode"}, {30'd0, mode}, {30'd0, m_mode});
        check({tag, "_presc"}, {16'd0, prescaler}, {16'd0, m_presc});
        check({tag, "_reload"}, reload_val, m_reload_live);
        check({tag, "_compare"}, compare_val, m_compare_live);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_flag & m_en});
    endtask

    task automatic timeout_rise_model();
        m_flag = 1'b1;
        if (SHADOW) begin m_reload_live = m_reload; m_compare_live = m_compare; end
    endtask

    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d, input bit to_at_commit);
        bit exp_err, exp_start;
        logic [31:0] exp_rd;
        int lat;
        exp_err = ((a >> 2) > 6) || (w && (a >> 2) == 6);
        exp_rd = (w || exp_err) ? 32'd0 : model_read(a);
        exp_start = 1'b0;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            penable = 1;
            lat++;
        end while (!pready && lat < 20);
        check("latency", 32'(lat), 32'(WS + 2));
        check("prdata", prdata, exp_rd);
        check("pslverr", {31'd0, pslverr}, {31'd0, exp_err});
        if (to_at_commit) timeout = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
        timeout = 0;
        if (to_at_commit && SHADOW) begin m_reload_live = m_reload; m_compare_live = m_compare; end
        if (w && !exp_err)
            case (a >> 2)
                0: begin m_mode = d[1:0]; exp_start = d[2]; end
                1: m_presc = d[15:0];
                2: begin m_reload = d; if (!SHADOW) m_reload_live = d; end
                3: begin m_compare = d; if (!SHADOW) m_compare_live = d; end
                4: if (d[0]) m_flag = 0;
                5: m_en = d[0];
                default: ;
            endcase
        if (to_at_commit) m_flag = 1;
        check("start", {31'd0, start}, {31'd0, exp_start});
        check("after_commit_irq", {31'd0, irq}, {31'd0, m_flag & m_en});
        @(posedge clk); #1;
        check("start_end", {31'd0, start}, 32'd0);
        if (exp_start && SHADOW) begin m_reload_live = m_reload; m_compare_live = m_compare; end
        check_outputs("post");
    endtask

    task automatic pulse_timeout();
        @(posedge clk); #1;
        check("irq_pre", {31'd0, irq}, {31'd0, m_flag & m_en});
        timeout = 1;
        @(posedge clk); #1;
        timeout_rise_model();
        check("irq_rise", {31'd0, irq}, {31'd0, m_en});
        timeout = 0;
        @(posedge clk); #1;
        check_outputs("pulse");
    endtask

    initial begin
        logic [7:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check_outputs("rst");
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 7; i++) apb(0, 8'(i * 4), 32'd0, 0);
        apb(1, 8'h08, 32'h0000_1000, 0);
        apb(0, 8'h08, 32'd0, 0);
        apb(1, 8'h00, 32'h6, 0);
        apb(0, 8'h00, 32'd0, 0);
        apb(1, 8'h24, 32'hFFFF_FFFF, 0);
        apb(1, 8'h18, 32'h1, 0);
        apb(1, 8'h14, 32'h1, 0);
        pulse_timeout();
        apb(0, 8'h10, 32'd0, 0);
        apb(1, 8'h10, 32'h3, 0);
        apb(0, 8'h10, 32'd0, 0);
        pulse_timeout();
        apb(1, 8'h10, 32'h1, 1);
        apb(0, 8'h10, 32'd0, 0);
        // abort: psel dropped while in ACCESS
        @(negedge clk);
        psel = 1; pwrite = 1; paddr = 8'h0C; pwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1;
        check("abort_pready0", {31'd0, pready}, 32'd0);
        psel = 0; penable = 0;
        @(posedge clk); #1;
        check("abort_pready1", {31'd0, pready}, 32'd0);
        check_outputs("abort");
        apb(0, 8'h0C, 32'd0, 0);
        // reset during the wait phase of a COMPARE write
        @(negedge clk);
        psel = 1; pwrite = 1; paddr = 8'h0C; pwdata = 32'h0000_0077;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0;
        model_reset();
        #1;
        check("midrst_pready", {31'd0, pready}, 32'd0);
        check_outputs("midrst");
        @(negedge clk); @(negedge clk); rst_n = 1;
        apb(0, 8'h0C, 32'd0, 0);
        apb(1, 8'h0C, 32'd5, 0);
        pulse_timeout();
        apb(0, 8'h0C, 32'd0, 0);
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            a = r <= 6 ? 8'(r * 4 + $urandom_range(0, 3)) : r == 7 ? 8'h1C : r == 8 ? 8'h24 : 8'($urandom);
            current_count = $urandom;
            pwm_out = 1'($urandom);
            if ($urandom_range(0, 5) == 0) pulse_timeout();
            apb(1'($urandom), a, $urandom, $urandom_range(0, 7) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
